glb_strm_f2g_source: RTL and testbench
======================================

# glb_strm_f2g_source

CGRA-side stream transmitter for the global buffer's fabric-to-GLB (f2g) streaming port. One instance per GLB tile channel. On a start pulse it emits a configured arithmetic sequence of words on `stream_data_f2g`/`stream_data_valid_f2g`, honouring `cgra_stall` and an inter-word gap. It then waits for the GLB's `strm_f2g_interrupt_pulse` to confirm the transfer completed. It is the data source the f2g receive path consumes, usable both in the bench and as a fabric-side traffic generator.

## Interface
- `CGRA_DATA_WIDTH`, default 16, width of a stream word.
- `CNT_WIDTH`, default 16, width of the word count and the timeout count.
- `GAP_WIDTH`, default 8, width of the inter-word gap count.

Ports (name, direction, width, meaning):
- `clk`, in, 1, the single clock.
- `reset`, in, 1, asynchronous, active-high; clears all state.
- `cfg_num_words`, in, CNT_WIDTH, number of words to send; latched at start.
- `cfg_start_value`, in, CGRA_DATA_WIDTH, first word value; latched at start.
- `cfg_stride`, in, CGRA_DATA_WIDTH, increment between consecutive words; latched at start.
- `cfg_gap`, in, GAP_WIDTH, idle cycles inserted between words; latched at start.
- `cfg_timeout`, in, CNT_WIDTH, cycles to wait for the interrupt; latched at start; used only with the macro.
- `strm_start_pulse`, in, 1, one-cycle start request.
- `cgra_stall`, in, 1, high blocks emission and freezes all counters.
- `strm_f2g_interrupt_pulse`, in, 1, completion pulse from the GLB.
- `stream_data_f2g`, out, CGRA_DATA_WIDTH, stream word.
- `stream_data_valid_f2g`, out, 1, word valid.
- `busy`, out, 1, high whenever state is not IDLE.
- `done_pulse`, out, 1, one-cycle, registered; marks the end of a transfer.
- `word_cnt`, out, CNT_WIDTH, number of words emitted since the last start.
- `timeout_err`, out, 1, sticky; cleared by reset or the next accepted start.

## Operation
- States: IDLE, SEND, GAP, WAIT_IRQ. Reset state is IDLE.
- Reset values: all outputs 0; `cur`, `remaining`, counters and latched cfg all 0.
- Start handling:
  - `strm_start_pulse` in IDLE latches cfg, sets `cur` = `cfg_start_value`, `remaining` = `cfg_num_words`, clears `word_cnt`, `timeout_err` and `irq_early`.
  - Next state is SEND, or if `cfg_num_words` == 0 the FSM stays IDLE and asserts `done_pulse` the next cycle.
  - `strm_start_pulse` while `busy` is ignored.
- Outputs: `stream_data_valid_f2g` = (state==SEND) && !`cgra_stall`. `stream_data_f2g` = `cur` register, always driven, 0 in reset.
- SEND, per cycle with `cgra_stall` low:
  - One word is emitted; `cur` += stride, modulo 2^CGRA_DATA_WIDTH, with wrap and no saturation.
  - `remaining` decrements and `word_cnt` increments.
  - If `remaining` was 1, go to WAIT_IRQ. Else if gap > 0, go to GAP with gap counter = gap. Else stay in SEND.
- SEND with `cgra_stall` high: no emission; state and counters hold.
- GAP: the gap counter decrements each unstalled cycle. On reaching 1, return to SEND. Stall freezes it.
- WAIT_IRQ:
  - On `strm_f2g_interrupt_pulse` or latched `irq_early`: go to IDLE with `done_pulse` next cycle.
- Early interrupt: a pulse during SEND or GAP sets `irq_early`; it is consumed on entry to WAIT_IRQ. The FSM leaves one cycle later.
- Simultaneous events:
  - Interrupt in the same cycle as the final word: treated as early, so exit follows one cycle later.
  - Start in the same cycle as `done_pulse`: accepted, because the state is already IDLE.
- Reset asserted mid-transfer: valid drops immediately (asynchronous) and the FSM returns to IDLE with no `done_pulse`.

## Timing
- Start pulse sampled at edge t: the first valid word appears in cycle t+1, if not stalled.
- Gap g: valid words are spaced g+1 cycles apart, absent stall.
- Final word in cycle w, interrupt sampled at edge i >= w+1: `done_pulse` is high in cycle i+1 and `busy` is low from cycle i+1.
- Zero-word start at edge t: `done_pulse` is high in cycle t+1; `busy` never rises.

## Configuration
- `GLB_F2G_TIMEOUT_EN` defined:
  - WAIT_IRQ loads a down-counter with `cfg_timeout` on entry; it decrements every cycle, stall ignored.
  - Reaching 0 without an interrupt sets `timeout_err`, pulses `done_pulse` and returns to IDLE.
  - `cfg_timeout` == 0 means time out on the first WAIT_IRQ cycle.
  - An interrupt in the same cycle as expiry wins, and no error is set.
- Not defined: no timeout counter. WAIT_IRQ waits indefinitely, `timeout_err` is tied to 0 and `cfg_timeout` is unused.

## Test plan
- Basic burst: num=4, start=0x0010, stride=1, gap=0, no stall -> valid in 4 consecutive cycles with data 0x0010..0x0013 and `word_cnt`=4. Interrupt 3 cycles later -> `done_pulse` the cycle after it, then `busy` low.
- Gap and stride: num=3, start=0, stride=5, gap=2 -> words 0, 5, 10 three cycles apart; `busy` high throughout.
- Stall: num=4, `cgra_stall` high for 2 cycles while 0x0012 is pending -> valid low for 2 cycles, `stream_data_f2g` holds 0x0012, exactly 4 words total with no duplicates.
- Wrap and zero length: start=0xFFFE, stride=1, num=3 -> 0xFFFE, 0xFFFF, 0x0000. Separately num=0 -> `done_pulse` at t+1, no valid, `busy` stays 0.
- Early interrupt and ignored restart: interrupt during the 2nd of 4 words, start re-pulsed mid-burst -> burst unchanged, `done_pulse` one cycle after WAIT_IRQ entry.
- Timeout and reset, with `GLB_F2G_TIMEOUT_EN`: timeout=5 and no interrupt -> `timeout_err`=1 and `done_pulse` 6 cycles after WAIT_IRQ entry. Reset asserted mid-SEND -> valid 0 immediately, IDLE, no `done_pulse`.

Source files
------------

// File: rtl/glb_strm_f2g_source.sv
// glb_strm_f2g_source: fabric-side f2g stream transmitter that emits an arithmetic word sequence.
// Define GLB_F2G_TIMEOUT_EN to bound the wait for the GLB completion interrupt.
module glb_strm_f2g_source #(
    parameter int CGRA_DATA_WIDTH = 16,
    parameter int CNT_WIDTH       = 16,
    parameter int GAP_WIDTH       = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CNT_WIDTH-1:0]       cfg_num_words,
    input  logic [CGRA_DATA_WIDTH-1:0] cfg_start_value,
    input  logic [CGRA_DATA_WIDTH-1:0] cfg_stride,
    input  logic [GAP_WIDTH-1:0]       cfg_gap,
    input  logic [CNT_WIDTH-1:0]       cfg_timeout,
    input  logic                       strm_start_pulse,
    input  logic                       cgra_stall,
    input  logic                       strm_f2g_interrupt_pulse,
    output logic [CGRA_DATA_WIDTH-1:0] stream_data_f2g,
    output logic                       stream_data_valid_f2g,
    output logic                       busy,
    output logic                       done_pulse,
    output logic [CNT_WIDTH-1:0]       word_cnt,
    output logic                       timeout_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        GAP      = 2'd2,
        WAIT_IRQ = 2'd3
    } state_t;

    state_t                     state_reg, state_next;
    logic [CGRA_DATA_WIDTH-1:0] cur_reg, cur_next;
    logic [CGRA_DATA_WIDTH-1:0] stride_reg, stride_next;
    logic [CNT_WIDTH-1:0]       remaining_reg, remaining_next;
    logic [CNT_WIDTH-1:0]       word_cnt_reg, word_cnt_next;
    logic [GAP_WIDTH-1:0]       gap_reg, gap_next;
    logic [GAP_WIDTH-1:0]       gap_cnt_reg, gap_cnt_next;
    logic                       irq_early_reg, irq_early_next;
    logic                       done_reg, done_next;
    logic                       timeout_err_reg, timeout_err_next;

`ifdef GLB_F2G_TIMEOUT_EN
    logic [CNT_WIDTH-1:0]       tmo_cfg_reg, tmo_cfg_next;
    logic [CNT_WIDTH-1:0]       tmo_cnt_reg, tmo_cnt_next;
`else
    logic                       unused_cfg_timeout;
    assign unused_cfg_timeout = ^cfg_timeout;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath and latched configuration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_reg         <= '0;
            stride_reg      <= '0;
            remaining_reg   <= '0;
            word_cnt_reg    <= '0;
            gap_reg         <= '0;
            gap_cnt_reg     <= '0;
            irq_early_reg   <= 1'b0;
            done_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
`ifdef GLB_F2G_TIMEOUT_EN
            tmo_cfg_reg     <= '0;
            tmo_cnt_reg     <= '0;
`endif
        end else begin
            cur_reg         <= cur_next;
            stride_reg      <= stride_next;
            remaining_reg   <= remaining_next;
            word_cnt_reg    <= word_cnt_next;
            gap_reg         <= gap_next;
            gap_cnt_reg     <= gap_cnt_next;
            irq_early_reg   <= irq_early_next;
            done_reg        <= done_next;
            timeout_err_reg <= timeout_err_next;
`ifdef GLB_F2G_TIMEOUT_EN
            tmo_cfg_reg     <= tmo_cfg_next;
            tmo_cnt_reg     <= tmo_cnt_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        cur_next         = cur_reg;
        stride_next      = stride_reg;
        remaining_next   = remaining_reg;
        word_cnt_next    = word_cnt_reg;
        gap_next         = gap_reg;
        gap_cnt_next     = gap_cnt_reg;
        irq_early_next   = irq_early_reg;
        done_next        = 1'b0;
        timeout_err_next = timeout_err_reg;
`ifdef GLB_F2G_TIMEOUT_EN
        tmo_cfg_next     = tmo_cfg_reg;
        tmo_cnt_next     = tmo_cnt_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (strm_start_pulse) begin
                    cur_next         = cfg_start_value;
                    stride_next      = cfg_stride;
                    remaining_next   = cfg_num_words;
                    gap_next         = cfg_gap;
                    word_cnt_next    = '0;
                    irq_early_next   = 1'b0;
                    timeout_err_next = 1'b0;
`ifdef GLB_F2G_TIMEOUT_EN
                    tmo_cfg_next     = cfg_timeout;
`endif
                    // An empty transfer completes without ever leaving IDLE.
                    if (cfg_num_words == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = SEND;
                    end
                end
            end

            SEND: begin
                if (strm_f2g_interrupt_pulse) begin
                    irq_early_next = 1'b1;
                end
                if (!cgra_stall) begin
                    cur_next       = cur_reg + stride_reg;
                    remaining_next = remaining_reg - CNT_WIDTH'(1);
                    word_cnt_next  = word_cnt_reg + CNT_WIDTH'(1);
                    if (remaining_reg == CNT_WIDTH'(1)) begin
                        state_next = WAIT_IRQ;
`ifdef GLB_F2G_TIMEOUT_EN
                        tmo_cnt_next = tmo_cfg_reg;
`endif
                    end else if (gap_reg != '0) begin
                        state_next   = GAP;
                        gap_cnt_next = gap_reg;
                    end
                end
            end

            GAP: begin
                if (strm_f2g_interrupt_pulse) begin
                    irq_early_next = 1'b1;
                end
                // The counter starts at gap, so gap idle cycles separate two words.
                if (!cgra_stall) begin
                    gap_cnt_next = gap_cnt_reg - GAP_WIDTH'(1);
                    if (gap_cnt_reg == GAP_WIDTH'(1)) begin
                        state_next = SEND;
                    end
                end
            end

            WAIT_IRQ: begin
                // A real interrupt takes priority over an expiring timeout.
                if (strm_f2g_interrupt_pulse || irq_early_reg) begin
                    state_next     = IDLE;
                    done_next      = 1'b1;
                    irq_early_next = 1'b0;
                end
`ifdef GLB_F2G_TIMEOUT_EN
                else if (tmo_cnt_reg == '0) begin
                    state_next       = IDLE;
                    done_next        = 1'b1;
                    timeout_err_next = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg - CNT_WIDTH'(1);
                end
`endif
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign stream_data_f2g       = cur_reg;
    assign stream_data_valid_f2g = (state_reg == SEND) && !cgra_stall;
    assign busy                  = (state_reg != IDLE);
    assign done_pulse            = done_reg;
    assign word_cnt              = word_cnt_reg;
`ifdef GLB_F2G_TIMEOUT_EN
    assign timeout_err           = timeout_err_reg;
`else
    assign timeout_err           = 1'b0;
`endif

endmodule

// File: tb/tb_glb_strm_f2g_source.sv
// Self-checking bench for glb_strm_f2g_source: directed and random transfers against a
// sequence/timing model; timeout scenarios run only when GLB_F2G_TIMEOUT_EN is defined.
module tb_glb_strm_f2g_source;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int GW = 8;
    localparam int TMO_BIG = 1000;
`ifdef GLB_F2G_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] cfg_num_words;
    logic [DW-1:0] cfg_start_value;
    logic [DW-1:0] cfg_stride;
    logic [GW-1:0] cfg_gap;
    logic [CW-1:0] cfg_timeout;
    logic          strm_start_pulse;
    logic          cgra_stall;
    logic          strm_f2g_interrupt_pulse;
    logic [DW-1:0] stream_data_f2g;
    logic          stream_data_valid_f2g;
    logic          busy;
    logic          done_pulse;
    logic [CW-1:0] word_cnt;
    logic          timeout_err;

    int errors = 0;
    int checks = 0;

    logic          s_valid, s_busy, s_done, s_err;
    logic [DW-1:0] s_data;
    logic [CW-1:0] s_wc;

    glb_strm_f2g_source #(
        .CGRA_DATA_WIDTH(DW),
        .CNT_WIDTH      (CW),
        .GAP_WIDTH      (GW)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cfg_num_words           (cfg_num_words),
        .cfg_start_value         (cfg_start_value),
        .cfg_stride              (cfg_stride),
        .cfg_gap                 (cfg_gap),
        .cfg_timeout             (cfg_timeout),
        .strm_start_pulse        (strm_start_pulse),
        .cgra_stall              (cgra_stall),
        .strm_f2g_interrupt_pulse(strm_f2g_interrupt_pulse),
        .stream_data_f2g         (stream_data_f2g),
        .stream_data_valid_f2g   (stream_data_valid_f2g),
        .busy                    (busy),
        .done_pulse              (done_pulse),
        .word_cnt                (word_cnt),
        .timeout_err             (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs held from just after a rising edge, outputs sampled at the falling edge.
    task automatic step(input logic st, input logic go, input logic irq);
        cgra_stall               = st;
        strm_start_pulse         = go;
        strm_f2g_interrupt_pulse = irq;
        @(negedge clk);
        s_valid = stream_data_valid_f2g;
        s_data  = stream_data_f2g;
        s_busy  = busy;
        s_done  = done_pulse;
        s_wc    = word_cnt;
        s_err   = timeout_err;
        @(posedge clk);
        #1;
        cgra_stall               = 1'b0;
        strm_start_pulse         = 1'b0;
        strm_f2g_interrupt_pulse = 1'b0;
    endtask

    // Step 0 is the start cycle. With no stall, word k is valid at step 1 + k*(gap+1).
    // Wait-phase step c=0 is the first WAIT_IRQ cycle; done follows the exit step.
    task automatic run_xfer(input int num, input logic [15:0] sv, input logic [15:0] sd,
                            input int gap, input int stall_pct, input int stall_from,
                            input int stall_len, input int irq_step, input int restart_step,
                            input int tmo, input int irq_delay, input bit done_at_start,
                            input bit leave_open);
        logic [15:0] exp_q[$];
        logic [15:0] w;
        int  got, s, exit_c;
        bit  early, st, exp_err, no_stall;
        exp_q = {};
        for (int k = 0; k < num; k++) begin
            w = sv + 16'(k * int'(sd));
            exp_q.push_back(w);
        end
        cfg_num_words   = 16'(num);
        cfg_start_value = sv;
        cfg_stride      = sd;
        cfg_gap         = 8'(gap);
        cfg_timeout     = 16'(tmo);
        step(1'b0, 1'b1, 1'b0);
        if (done_at_start) chk("chain_done", 32'(s_done), 32'd1);
        cfg_num_words   = 16'($urandom_range(1, 50));
        cfg_start_value = 16'($urandom);
        cfg_stride      = 16'($urandom);
        cfg_gap         = 8'($urandom_range(0, 5));
        cfg_timeout     = 16'($urandom_range(0, 3));

        if (num == 0) begin
            step(1'b0, 1'b0, 1'b0);
            chk("zero_done", 32'(s_done), 32'd1);
            chk("zero_busy", 32'(s_busy), 32'd0);
            chk("zero_valid", 32'(s_valid), 32'd0);
            step(1'b0, 1'b0, 1'b0);
            chk("zero_done_drop", 32'(s_done), 32'd0);
            chk("zero_busy_after", 32'(s_busy), 32'd0);
            $display("xfer num=0 start=%h: empty transfer", sv);
            return;
        end

        got = 0;
        s = 1;
        early = 1'b0;
        no_stall = (stall_pct == 0) && (stall_len == 0);
        while (got < num && s < 3000) begin
            st = ((s >= stall_from) && (s < stall_from + stall_len)) ||
                 (int'($urandom_range(99)) < stall_pct);
            if (s == irq_step) early = 1'b1;
            step(st, s == restart_step, s == irq_step);
            chk("send_busy", 32'(s_busy), 32'd1);
            chk("err_cleared", 32'(s_err), 32'd0);
            chk("pending_data", 32'(s_data), 32'(exp_q[got]));
            if (st) chk("stall_valid", 32'(s_valid), 32'd0);
            if (s_valid) begin
                chk("word_cnt", 32'(s_wc), 32'(got));
                if (no_stall) chk("spacing", 32'(s), 32'(1 + got * (gap + 1)));
                got++;
            end
            s++;
        end
        if (got < num) chk("burst_budget", 32'(got), 32'(num));

        if (early) begin
            exit_c = 0;
            exp_err = 1'b0;
        end else if (irq_delay >= 0 && (!TMO_ON || irq_delay <= tmo)) begin
            exit_c = irq_delay;
            exp_err = 1'b0;
        end else begin
            exit_c = tmo;
            exp_err = TMO_ON;
        end

        for (int c = 0; c <= exit_c; c++) begin
            step(1'b0, 1'b0, !early && (c == irq_delay));
            chk("wait_busy", 32'(s_busy), 32'd1);
            chk("wait_valid", 32'(s_valid), 32'd0);
            chk("wait_done", 32'(s_done), 32'd0);
            chk("final_cnt", 32'(s_wc), 32'(num));
        end
        $display("xfer num=%0d start=%h stride=%h gap=%0d stall=%0d words=%0d early=%0b exit_c=%0d err=%0b",
                 num, sv, sd, gap, stall_pct + stall_len, got, early, exit_c, exp_err);
        if (leave_open) return;

        step(1'b0, 1'b0, 1'b0);
        chk("done", 32'(s_done), 32'd1);
        chk("idle_after_done", 32'(s_busy), 32'd0);
        chk("timeout_err", 32'(s_err), 32'(exp_err));
        step(1'b0, 1'b0, 1'b0);
        chk("done_drop", 32'(s_done), 32'd0);
        chk("err_sticky", 32'(s_err), 32'(exp_err));
    endtask

    initial begin
        int num, gap, pct, irq_s, tmo, idly;
        reset                    = 1'b1;
        cfg_num_words            = '0;
        cfg_start_value          = '0;
        cfg_stride               = '0;
        cfg_gap                  = '0;
        cfg_timeout              = '0;
        strm_start_pulse         = 1'b0;
        cgra_stall               = 1'b0;
        strm_f2g_interrupt_pulse = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(stream_data_valid_f2g), 32'd0);
        chk("rst_data", 32'(stream_data_f2g), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done_pulse), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("idle_busy", 32'(s_busy), 32'd0);
        chk("idle_done", 32'(s_done), 32'd0);

        // Basic burst, interrupt three cycles into the wait
        run_xfer(4, 16'h0010, 16'h0001, 0, 0, 0, 0, -1, -1, TMO_BIG, 3, 1'b0, 1'b0);
        // Gap and stride
        run_xfer(3, 16'h0000, 16'h0005, 2, 0, 0, 0, -1, -1, TMO_BIG, 0, 1'b0, 1'b0);
        // Two stall cycles while 0x0012 is pending
        run_xfer(4, 16'h0010, 16'h0001, 0, 0, 3, 2, -1, -1, TMO_BIG, 1, 1'b0, 1'b0);
        // Wrap past the top of the data range
        run_xfer(3, 16'hFFFE, 16'h0001, 0, 0, 0, 0, -1, -1, TMO_BIG, 2, 1'b0, 1'b0);
        // Zero-length transfer
        run_xfer(0, 16'h1234, 16'h0001, 0, 0, 0, 0, -1, -1, TMO_BIG, 0, 1'b0, 1'b0);
        // Early interrupt on the 2nd word, ignored restart on the 3rd
        run_xfer(4, 16'h0020, 16'h0003, 0, 0, 0, 0, 2, 3, TMO_BIG, 5, 1'b0, 1'b0);
        // Interrupt coincident with the final word
        run_xfer(3, 16'h0100, 16'h0010, 1, 0, 0, 0, 5, -1, TMO_BIG, 4, 1'b0, 1'b0);
        // Start accepted in the same cycle as done_pulse
        run_xfer(2, 16'h0200, 16'h0002, 0, 0, 0, 0, -1, -1, TMO_BIG, 1, 1'b0, 1'b1);
        run_xfer(3, 16'h0300, 16'h0004, 1, 0, 0, 0, -1, -1, TMO_BIG, 0, 1'b1, 1'b0);

`ifdef GLB_F2G_TIMEOUT_EN
        run_xfer(2, 16'h0400, 16'h0001, 0, 0, 0, 0, -1, -1, 5, -1, 1'b0, 1'b0);
        run_xfer(2, 16'h0500, 16'h0001, 0, 0, 0, 0, -1, -1, 0, -1, 1'b0, 1'b0);
        run_xfer(2, 16'h0600, 16'h0001, 0, 0, 0, 0, -1, -1, 2, 2, 1'b0, 1'b0);
        run_xfer(3, 16'h0700, 16'h0001, 0, 0, 0, 0, 3, -1, 0, -1, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 12; n++) begin
            num   = int'($urandom_range(1, 10));
            gap   = int'($urandom_range(0, 3));
            pct   = ($urandom_range(1) == 1) ? 30 : 0;
            irq_s = ($urandom_range(3) == 0) ? int'($urandom_range(1, num)) : -1;
            tmo   = int'($urandom_range(0, 6));
            idly  = int'($urandom_range(0, 8));
            run_xfer(num, 16'($urandom), 16'($urandom), gap, pct, 0, 0, irq_s, -1,
                     tmo, idly, 1'b0, 1'b0);
        end

        // Reset asserted mid-SEND
        cfg_num_words   = 16'd10;
        cfg_start_value = 16'h0055;
        cfg_stride      = 16'h0003;
        cfg_gap         = 8'd0;
        cfg_timeout     = 16'(TMO_BIG);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(s_valid), 32'd1);
        chk("pre_rst_data", 32'(s_data), 32'h0055);
        reset = 1'b1;
        #1;
        chk("rst_async_valid", 32'(stream_data_valid_f2g), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rst_mid_done", 32'(done_pulse), 32'd0);
        chk("rst_mid_word_cnt", 32'(word_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("post_rst_done", 32'(s_done), 32'd0);
        chk("post_rst_busy", 32'(s_busy), 32'd0);
        chk("post_rst_valid", 32'(s_valid), 32'd0);
        $display("xfer num=10 start=0055: reset mid-burst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
